video_timing_gen: RTL and testbench

Parametrised raster timing generator. It is the successor to the fixed 640x480 sync generator at the head of the video pipeline. It derives a pixel-clock enable from `pclk` by an integer divider and emits registered, mutually aligned `x`/`y` position, display-enable, sync (with configurable polarity) and line/frame strobes. An optional raster-line compare strobe supports mid-frame register updates. Downstream video sub-modules qualify all work with `pc_ena`.

---
 rtl/video_timing_pkg.sv | 47 ++++
 rtl/video_timing_gen_pix_clk_div.sv | 47 ++++
 rtl/video_timing_gen.sv | 172 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared types and helpers for the raster timing generator.
//   timing_t         : resolution / porch / sync geometry of one video mode
//   VGA_640x480_60   : 640x480 @ 60 Hz preset
//   SVGA_800x600_60  : 800x600 @ 60 Hz preset
//   h_total/v_total  : total pixels per line / lines per frame
//   fits_cw          : true when a value is representable in cw unsigned bits
package video_timing_pkg;

  localparam int PHASE_W = 4;

  typedef struct packed {
    int h_res;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_res;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;

  localparam timing_t VGA_640x480_60 = '{
    h_res: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_res: 480, v_fp: 10, v_sync: 2,   v_bp: 33
  };

  localparam timing_t SVGA_800x600_60 = '{
    h_res: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_res: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
  };

  function automatic int h_total(timing_t t);
    return t.h_res + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int v_total(timing_t t);
    return t.v_res + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  function automatic bit fits_cw(int val, int cw);
    if (val < 0)   return 1'b0;
    if (cw >= 31)  return 1'b1;
    return val < (1 << cw);
  endfunction

endpackage

// File: rtl/video_timing_gen_pix_clk_div.sv
// pix_clk_div
// Integer divider producing the pixel-clock enable from pclk.
// Ports:
//   i_pclk   : base pixel clock
//   i_rst_n  : asynchronous active-low reset
//   o_phase  : pclk index within the current pixel, 0..PIX_DIV-1
//   o_ena    : registered strobe, high on the first pclk of each pixel
//   o_adv    : combinational wrap flag; the coming edge starts a new pixel
module pix_clk_div
  import video_timing_pkg::*;
#(
  parameter int PIX_DIV = 4
) (
  input  logic               i_pclk,
  input  logic               i_rst_n,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_ena,
  output logic               o_adv
);

  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(PIX_DIV - 1);

  logic [PHASE_W-1:0] r_phase;
  logic               r_ena;
  logic               w_wrap;
  logic [PHASE_W-1:0] w_phase_nxt;

  assign w_wrap      = (r_phase == PH_LAST);
  assign w_phase_nxt = w_wrap ? '0 : r_phase + PHASE_W'(1);

  // Reset parks on the last phase so the first edge after release wraps
  // into phase 0 and starts pixel (0,0).
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= PH_LAST;
      r_ena   <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_ena   <= w_wrap;
    end
  end

  assign o_phase = r_phase;
  assign o_ena   = r_ena;
  assign o_adv   = w_wrap;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Parametrised raster timing generator. All outputs are registered decodes
// of the next position, so they are aligned with x/y.
// Optional feature: define VIDEO_TIMING_RASTER_IRQ_EN to add the raster-line
// compare (raster_line input, raster_irq strobe).
// Ports:
//   pclk        : base pixel clock
//   reset       : asynchronous active-low reset
//   pc_ena      : strobe on the first pclk of each pixel
//   pc_phase    : pclk index within the pixel
//   x, y        : current raster position
//   hde/vde/de  : display enables
//   hsync/vsync : syncs, asserted level set by HS_POL / VS_POL
//   line_start  : strobe at x==0
//   frame_start : strobe at x==0, y==0
//   raster_line : compare line (optional)
//   raster_irq  : strobe at line start of y==raster_line (optional)
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int HS_POL  = 1,
  parameter int VS_POL  = 1,
  parameter int PIX_DIV = 4,
  parameter int CW      = 12
) (
  input  logic               pclk,
  input  logic               reset,
  output logic               pc_ena,
  output logic [PHASE_W-1:0] pc_phase,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               hde,
  output logic               vde,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
`ifdef VIDEO_TIMING_RASTER_IRQ_EN
  ,
  input  logic [CW-1:0]      raster_line,
  output logic               raster_irq
`endif
);

  localparam timing_t TIM = '{
    h_res: H_RES, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_res: V_RES, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
  };
  localparam int H_TOTAL = h_total(TIM);
  localparam int V_TOTAL = v_total(TIM);

  generate
    if (!fits_cw(H_TOTAL - 1, CW) || !fits_cw(V_TOTAL - 1, CW)) begin : g_cw_err
      $error("video_timing_gen: CW=%0d too narrow for H_TOTAL=%0d V_TOTAL=%0d",
             CW, H_TOTAL, V_TOTAL);
    end
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_div_err
      $error("video_timing_gen: PIX_DIV=%0d outside 1..16", PIX_DIV);
    end
  endgenerate

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT    = CW'(H_RES);
  localparam logic [CW-1:0] Y_ACT    = CW'(V_RES);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_RES + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_RES + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_RES + V_FP + V_SYNC - 1);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic          w_adv;
  logic [CW-1:0] w_x_nxt;
  logic [CW-1:0] w_y_nxt;
  logic          w_line_hit;

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_hde;
  logic          r_vde;
  logic          r_de;
  logic          r_hs;
  logic          r_vs;
  logic          r_ls;
  logic          r_fs;

  pix_clk_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_clk_div (
    .i_pclk  (pclk),
    .i_rst_n (reset),
    .o_phase (pc_phase),
    .o_ena   (pc_ena),
    .o_adv   (w_adv)
  );

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_adv) begin
      if (r_x == X_LAST) begin
        w_x_nxt = '0;
        w_y_nxt = (r_y == Y_LAST) ? '0 : r_y + CW'(1);
      end else begin
        w_x_nxt = r_x + CW'(1);
      end
    end
  end

  // Strobes qualify on w_adv so they last only the first pclk of a pixel.
  assign w_line_hit = w_adv && (w_x_nxt == '0);

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_x   <= X_LAST;
      r_y   <= Y_LAST;
      r_hde <= 1'b0;
      r_vde <= 1'b0;
      r_de  <= 1'b0;
      r_hs  <= ~HS_ON;
      r_vs  <= ~VS_ON;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_hde <= (w_x_nxt < X_ACT);
      r_vde <= (w_y_nxt < Y_ACT);
      r_de  <= (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
      r_hs  <= (w_x_nxt >= HS_FIRST && w_x_nxt <= HS_LAST) ? HS_ON : ~HS_ON;
      r_vs  <= (w_y_nxt >= VS_FIRST && w_y_nxt <= VS_LAST) ? VS_ON : ~VS_ON;
      r_ls  <= w_line_hit;
      r_fs  <= w_line_hit && (w_y_nxt == '0);
    end
  end

`ifdef VIDEO_TIMING_RASTER_IRQ_EN
  logic r_irq;

  // y never exceeds V_TOTAL-1, so an out-of-range compare line never matches.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_line_hit && (w_y_nxt == raster_line);
    end
  end

  assign raster_irq = r_irq;
`endif

  assign x           = r_x;
  assign y           = r_y;
  assign hde         = r_hde;
  assign vde         = r_vde;
  assign de          = r_de;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int HR  = 8;
  localparam int HF  = 1;
  localparam int HSW = 2;
  localparam int HB  = 1;
  localparam int VR  = 4;
  localparam int VF  = 1;
  localparam int VSW = 1;
  localparam int VB  = 1;
  localparam int D   = 3;
  localparam int CW  = 8;
  localparam bit HP  = 1'b0;
  localparam bit VP  = 1'b1;
  localparam int HT  = HR + HF + HSW + HB;   // 12
  localparam int VT  = VR + VF + VSW + VB;   // 7

  typedef struct packed {
    logic          ena;
    logic [3:0]    ph;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hde;
    logic          vde;
    logic          de;
    logic          hs;
    logic          vs;
    logic          ls;
    logic          fs;
    logic          irq;
  } obs_t;

  typedef struct {
    int k;
    int ph;
    int x;
    int y;
    bit ena, hde, vde, hs, vs, ls, fs;
  } vec_t;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] raster_line = '1;
  logic          pc_ena, hde, vde, de, hsync, vsync, line_start, frame_start;
  logic [3:0]    pc_phase;
  logic [CW-1:0] x, y;
  logic          irq_sig;
  obs_t          dut_o;

  int k = 0;
  int vectors = 0;
  int miscompares = 0;

  video_timing_gen #(
    .H_RES(HR), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_RES(VR), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .PIX_DIV(D), .CW(CW)
  ) dut (
    .pclk        (pclk),
    .reset       (reset),
    .pc_ena      (pc_ena),
    .pc_phase    (pc_phase),
    .x           (x),
    .y           (y),
    .hde         (hde),
    .vde         (vde),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VIDEO_TIMING_RASTER_IRQ_EN
    ,
    .raster_line (raster_line),
    .raster_irq  (irq_sig)
`endif
  );

`ifndef VIDEO_TIMING_RASTER_IRQ_EN
  assign irq_sig = 1'b0;
`endif

  assign dut_o = {pc_ena, pc_phase, x, y, hde, vde, de, hsync, vsync,
                  line_start, frame_start, irq_sig};

  always #5 pclk = ~pclk;

  // k = number of pclk edges since reset release (0 while in reset)
  always @(posedge pclk or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  // Reference: position from elapsed cycles by plain arithmetic.
  function automatic obs_t model(int kk, logic [CW-1:0] rl);
    obs_t o;
    int p, ph, xx, yy;
    o = '0;
    if (kk == 0) begin
      o.ph = 4'(D - 1);
      o.x  = CW'(HT - 1);
      o.y  = CW'(VT - 1);
      o.hs = !HP;
      o.vs = !VP;
      return o;
    end
    p  = (kk - 1) / D;
    ph = (kk - 1) % D;
    xx = p % HT;
    yy = (p / HT) % VT;
    o.ena = (ph == 0);
    o.ph  = 4'(ph);
    o.x   = CW'(xx);
    o.y   = CW'(yy);
    o.hde = (xx < HR);
    o.vde = (yy < VR);
    o.de  = o.hde && o.vde;
    o.hs  = (xx >= HR + HF && xx < HR + HF + HSW) ? HP : !HP;
    o.vs  = (yy >= VR + VF && yy < VR + VF + VSW) ? VP : !VP;
    o.ls  = o.ena && (xx == 0);
    o.fs  = o.ls && (yy == 0);
`ifdef VIDEO_TIMING_RASTER_IRQ_EN
    o.irq = o.ls && (yy == int'(rl));
`endif
    return o;
  endfunction

  function automatic obs_t to_obs(vec_t e);
    obs_t o;
    o = '0;
    o.ena = e.ena;
    o.ph  = 4'(e.ph);
    o.x   = CW'(e.x);
    o.y   = CW'(e.y);
    o.hde = e.hde;
    o.vde = e.vde;
    o.de  = e.hde && e.vde;
    o.hs  = e.hs;
    o.vs  = e.vs;
    o.ls  = e.ls;
    o.fs  = e.fs;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h (x=%0d y=%0d ph=%0d) expected %h (x=%0d y=%0d ph=%0d) k=%0d",
               name, act, act.x, act.y, act.ph, exp, exp.x, exp.y, exp.ph, k);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input bit fs_sel, input int bound, output int n);
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!(fs_sel ? frame_start : line_start) && n < bound);
  endtask

  vec_t tbl[$];
  obs_t rst_exp;
  int   n, guard, pulses, rst_hold;
  bit   found;

  initial begin
    // ph x y ena hde vde hs vs ls fs ; hsync asserted low at x 9,10; vsync high at y 5
    tbl.push_back('{k:1,   ph:0, x:0,  y:0, ena:1, hde:1, vde:1, hs:1, vs:0, ls:1, fs:1});
    tbl.push_back('{k:2,   ph:1, x:0,  y:0, ena:0, hde:1, vde:1, hs:1, vs:0, ls:0, fs:0});
    tbl.push_back('{k:3,   ph:2, x:0,  y:0, ena:0, hde:1, vde:1, hs:1, vs:0, ls:0, fs:0});
    tbl.push_back('{k:4,   ph:0, x:1,  y:0, ena:1, hde:1, vde:1, hs:1, vs:0, ls:0, fs:0});
    tbl.push_back('{k:24,  ph:2, x:7,  y:0, ena:0, hde:1, vde:1, hs:1, vs:0, ls:0, fs:0});
    tbl.push_back('{k:25,  ph:0, x:8,  y:0, ena:1, hde:0, vde:1, hs:1, vs:0, ls:0, fs:0});
    tbl.push_back('{k:28,  ph:0, x:9,  y:0, ena:1, hde:0, vde:1, hs:0, vs:0, ls:0, fs:0});
    tbl.push_back('{k:31,  ph:0, x:10, y:0, ena:1, hde:0, vde:1, hs:0, vs:0, ls:0, fs:0});
    tbl.push_back('{k:34,  ph:0, x:11, y:0, ena:1, hde:0, vde:1, hs:1, vs:0, ls:0, fs:0});
    tbl.push_back('{k:37,  ph:0, x:0,  y:1, ena:1, hde:1, vde:1, hs:1, vs:0, ls:1, fs:0});
    tbl.push_back('{k:145, ph:0, x:0,  y:4, ena:1, hde:1, vde:0, hs:1, vs:0, ls:1, fs:0});
    tbl.push_back('{k:181, ph:0, x:0,  y:5, ena:1, hde:1, vde:0, hs:1, vs:1, ls:1, fs:0});
    tbl.push_back('{k:214, ph:0, x:11, y:5, ena:1, hde:0, vde:0, hs:1, vs:1, ls:0, fs:0});
    tbl.push_back('{k:217, ph:0, x:0,  y:6, ena:1, hde:1, vde:0, hs:1, vs:0, ls:1, fs:0});
    tbl.push_back('{k:252, ph:2, x:11, y:6, ena:0, hde:0, vde:0, hs:1, vs:0, ls:0, fs:0});
    tbl.push_back('{k:253, ph:0, x:0,  y:0, ena:1, hde:1, vde:1, hs:1, vs:0, ls:1, fs:1});

    rst_exp     = '0;
    rst_exp.ph  = 4'd2;
    rst_exp.x   = CW'(11);
    rst_exp.y   = CW'(6);
    rst_exp.hs  = 1'b1;
    rst_exp.vs  = 1'b0;

    #2 reset = 1'b0;
    repeat (3) @(negedge pclk);
    check("reset_state", dut_o, rst_exp);

    reset = 1'b1;
    foreach (tbl[i]) begin
      guard = 0;
      while (k < tbl[i].k && guard < 400) begin
        @(negedge pclk);
        guard++;
      end
      check($sformatf("tbl_k%0d", tbl[i].k), dut_o, to_obs(tbl[i]));
    end

    wait_strobe(1'b1, 300, n);
    wait_strobe(1'b1, 400, n);
    check_int("frame_gap", n, HT * VT * D);
    wait_strobe(1'b0, 50, n);
    wait_strobe(1'b0, 50, n);
    check_int("line_gap", n, HT * D);

    // mid-frame asynchronous reset
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge pclk);
      if (x == CW'(5) && y == CW'(3)) found = 1'b1;
    end
    check_int("seek_x5y3", int'(found), 1);
    reset = 1'b0;
    #1;
    check("midframe_rst_now", dut_o, rst_exp);
    @(negedge pclk);
    check("midframe_rst_hold", dut_o, rst_exp);
    reset = 1'b1;
    @(negedge pclk);
    check("post_rst_first", dut_o, to_obs(tbl[0]));

`ifdef VIDEO_TIMING_RASTER_IRQ_EN
    raster_line = CW'(3);
    wait_strobe(1'b1, 300, n);
    pulses = 0;
    for (int i = 0; i < HT * VT * D; i++) begin
      if (irq_sig) begin
        pulses++;
        check_int("irq_pos", int'(line_start && x == 0 && y == CW'(3)), 1);
      end
      @(negedge pclk);
    end
    check_int("irq_count_line3", pulses, 1);

    raster_line = CW'(VT);
    pulses = 0;
    for (int i = 0; i < 3 * HT * VT * D; i++) begin
      @(negedge pclk);
      if (irq_sig) pulses++;
    end
    check_int("irq_count_out_of_range", pulses, 0);
`endif

    rst_hold = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge pclk);
      check("rand", dut_o, model(k, raster_line));
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        #1;
        check("rand_async_rst", dut_o, model(0, raster_line));
        rst_hold = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 39) == 0) raster_line = CW'($urandom_range(0, VT + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
